// File: rtl/seq_det_sched_if.sv
// Handshake bundle for seq_det_sched: requester frames, detector link, result.
// slave = scheduler side, master = requesters/detector/consumer side.
interface seq_det_sched_if #(
   parameter int NREQ    = 4,
   parameter int FRAME_W = 16,
   parameter int HIT_W   = $clog2(FRAME_W + 1)
);
   localparam int ID_W = $clog2(NREQ);

   logic [NREQ-1:0]         req_valid;
   logic [NREQ*FRAME_W-1:0] req_data;
   logic [NREQ-1:0]         req_ready;
   logic                    det_in;
   logic                    det_clr;
   logic                    det_out;
   logic                    res_valid;
   logic [ID_W-1:0]         res_id;
   logic [HIT_W-1:0]        res_hits;
   logic                    res_ready;

   modport slave (
      input  req_valid, req_data, det_out, res_ready,
      output req_ready, det_in, det_clr, res_valid, res_id, res_hits
   );

   modport master (
      output req_valid, req_data, det_out, res_ready,
      input  req_ready, det_in, det_clr, res_valid, res_id, res_hits
   );
endinterface

// File: rtl/seq_det_sched.sv
// seq_det_sched: shares one serial 1110010 detector among NREQ requesters.
// Ports: clk, rst (sync, active high), io_bus (seq_det_sched_if.slave).
// Macro SEQ_DET_SCHED_RR_EN: round-robin grant; undefined: lowest index wins.
module seq_det_sched #(
   parameter int NREQ    = 4,
   parameter int FRAME_W = 16,
   parameter int HIT_W   = $clog2(FRAME_W + 1)
) (
   input logic           clk,
   input logic           rst,
   seq_det_sched_if.slave io_bus
);
   localparam int ID_W = $clog2(NREQ);
   localparam int BC_W = $clog2(FRAME_W);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_RESULT
   } state_t;

   state_t             r_state, w_next;
   logic [FRAME_W-1:0] r_sh;
   logic [BC_W-1:0]    r_bit;
   logic [HIT_W-1:0]   r_hits;
   logic [ID_W-1:0]    r_id;
   logic [ID_W-1:0]    w_gnt;
   logic               w_any;
   logic [FRAME_W-1:0] w_data;
   logic               w_sample;

`ifdef SEQ_DET_SCHED_RR_EN
   logic [ID_W-1:0] r_last;
   logic [ID_W:0]   w_idx;

   // Search starts one past the last winner, wrapping at NREQ.
   always_comb begin
      w_any = 1'b0;
      w_gnt = '0;
      w_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = {1'b0, r_last} + (ID_W+1)'(k);
         if (w_idx >= (ID_W+1)'(NREQ))
            w_idx = w_idx - (ID_W+1)'(NREQ);
         if (!w_any && io_bus.req_valid[w_idx[ID_W-1:0]]) begin
            w_any = 1'b1;
            w_gnt = w_idx[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_last <= ID_W'(NREQ - 1);
      else if (r_state == S_IDLE && w_any)
         r_last <= w_gnt;
   end
`else
   always_comb begin
      w_any = |io_bus.req_valid;
      w_gnt = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (io_bus.req_valid[i]) w_gnt = ID_W'(i);
   end
`endif

   always_comb begin
      w_data = '0;
      for (int i = 0; i < NREQ; i++)
         if (w_gnt == ID_W'(i))
            w_data = io_bus.req_data[i*FRAME_W +: FRAME_W];
   end

   // det_out lags the presented bit by one cycle, so the first shift
   // cycle is skipped and DRAIN picks up the last bit.
   assign w_sample = (r_state == S_SHIFT && r_bit != '0) ||
                     (r_state == S_DRAIN);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next            = r_state;
      io_bus.req_ready  = '0;
      io_bus.det_in     = 1'b0;
      io_bus.det_clr    = rst;
      io_bus.res_valid  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_next = S_CLEAR;
               if (!rst) io_bus.req_ready[w_gnt] = 1'b1;
            end
         end
         S_CLEAR: begin
            io_bus.det_clr = 1'b1;
            w_next         = S_SHIFT;
         end
         S_SHIFT: begin
            io_bus.det_in = r_sh[FRAME_W-1];
            if (r_bit == BC_W'(FRAME_W - 1)) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            w_next = S_RESULT;
         end
         S_RESULT: begin
            io_bus.res_valid = 1'b1;
            if (io_bus.res_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh   <= '0;
         r_bit  <= '0;
         r_hits <= '0;
         r_id   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_sh <= w_data;
                  r_id <= w_gnt;
               end
            end
            S_CLEAR: begin
               r_bit  <= '0;
               r_hits <= '0;
            end
            S_SHIFT: begin
               r_sh  <= {r_sh[FRAME_W-2:0], 1'b0};
               r_bit <= r_bit + 1'b1;
            end
            default: ;
         endcase
         if (w_sample && io_bus.det_out && !(&r_hits))
            r_hits <= r_hits + 1'b1;
      end
   end

   assign io_bus.res_id   = r_id;
   assign io_bus.res_hits = r_hits;
endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Round-robin scheduler that shares one serial sequence detector (Moore FSM, pattern 1110010, one-bit `in`/`out`) among NREQ frame requesters. It accepts one FRAME_W-bit frame per grant and clears the detector. It then shifts the frame MSB-first into the detector, counts detector hits, and returns a tagged hit count on a result handshake. It sits between the requester ports and the single detector instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `FRAME_W`, 16: frame length in bits, 8..64.
- `HIT_W`, $clog2(FRAME_W+1): hit counter width.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: per-requester frame valid.
- `req_data` in NREQ*FRAME_W: frames; requester i at bits [i*FRAME_W +: FRAME_W].
- `req_ready` out NREQ: one-hot accept pulse.
- `det_in` out 1: serial bit to detector `in`.
- `det_clr` out 1: active-high clear of the detector to s0.
- `det_out` in 1: detector output, high while detector is in s7.
- `res_valid` out 1: result valid.
- `res_id` out $clog2(NREQ): index of the served requester.
- `res_hits` out HIT_W: number of detector hits in the frame.
- `res_ready` in 1: result consumer ready.

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, RESULT.
- IDLE: if any `req_valid`, grant winner g. Pulse `req_ready[g]` for 1 cycle. Latch `req_data[g]` into the shift register and g into `res_id`. Go to CLEAR. No grant when no request.
- CLEAR: `det_clr`=1 for one cycle. Zero hit counter and bit counter. Go to SHIFT.
- SHIFT: FRAME_W cycles. `det_in` = shift-register MSB; shift left each cycle. From the 2nd SHIFT cycle on, increment hits when `det_out`=1. After the FRAME_W-th bit, go to DRAIN.
- DRAIN: `det_in`=0. Sample `det_out` once more for the last bit. Go to RESULT.
- RESULT: `res_valid`=1. `res_id`/`res_hits` held stable until `res_valid && res_ready`, then go to IDLE.
- Arbitration: round-robin pointer `last` (reset NREQ-1). Search starts at `last+1` mod NREQ. `last` updates to g on each grant.
- Hit counter is saturating at all-ones (unreachable for legal FRAME_W; kept for safety).
- `req_valid` deasserting without a grant is legal; requester is simply not considered.
- Frames of non-granted requesters are never read.

## Timing
- Reset values: state IDLE, `req_ready`=0, `det_in`=0, `res_valid`=0, `res_id`=0, `res_hits`=0, `last`=NREQ-1.
- `det_clr`=1 in every cycle `rst` is high and in CLEAR; 0 otherwise.
- Accept in cycle A: CLEAR at A+1. SHIFT at A+2..A+FRAME_W+1 (bit k at A+2+k). DRAIN at A+FRAME_W+2. `res_valid` first high at A+FRAME_W+3.
- Hit sampling: `det_out` in cycle c reflects the bit presented in c-1 (Moore, one-cycle lag). Sampling windows are A+3..A+FRAME_W+2.
- Back-to-back: result handshake at cycle R gives IDLE at R+1, and the earliest next accept is at R+1. Minimum frame period is FRAME_W+4 cycles.
- `req_ready` is combinational from state and arbitration; at most one bit set, only in IDLE.
- `rst` mid-operation (any state): next cycle is IDLE with all reset values. The in-flight frame is dropped with no result. `det_clr` is high during reset.
- `res_ready` is ignored outside RESULT.

## Configuration
- `SEQ_DET_SCHED_RR_EN` defined: round-robin arbitration as above.
- Not defined: fixed priority, lowest index wins. `last` register is removed.
- Timing, handshakes and results are otherwise identical.

## Test plan
Bench connects the team's 1110010 sequence detector with `det_clr` driving its reset. NREQ=4, FRAME_W=16.
- Single frame 16'hE400 from req 1, `res_ready`=1: accept at A gives `res_valid` at A+19 with `res_id`=1 and `res_hits`=1.
- Frame 16'hE4E4 gives `res_hits`=2. 16'h0000 gives 0. 16'hFFFF gives 0 (detector held in s3). Each result is preceded by exactly one `det_clr` cycle after the accept.
- Reqs 0,1,2 valid continuously: grants 0,1,2,0,1,2 with RR macro defined; 0,0,0,... without it. Frame period is 20 cycles.
- `res_ready` held low 10 cycles in RESULT: `res_valid`/`res_id`/`res_hits` stable and no `req_ready` pulse. Release gives a grant on the following cycle.
- `rst` pulsed in the 5th SHIFT cycle: next cycle IDLE with all outputs at reset values and no result for the dropped frame. The next grant goes to req 0.
